// File: rtl/lz77_pkg.sv
// Shared LZ77 constants and FSM state type, imported by both encoder and decoder.
package lz77_pkg;
    localparam int SEARCH_LEN = 9;
    localparam int MAX_MATCH  = 7;
    localparam int DW         = 8;
    localparam int OFS_W      = 4;
    localparam int LEN_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        LIT  = 2'd2
    } state_t;
endpackage

// File: rtl/lz77_search_buf.sv
// Search-buffer shift register (entry 0 = newest byte) with offset read mux
// and a saturating count of bytes written.
module lz77_search_buf
    import lz77_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic [DW-1:0]    wr_data,
    input  logic [OFS_W-1:0] rd_pos,
    output logic [DW-1:0]    rd_data,
    output logic [OFS_W-1:0] fill
);
    logic [DW-1:0] mem [SEARCH_LEN];

    // Shift the new byte into entry 0; the oldest entry falls off the end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SEARCH_LEN; i++) mem[i] <= '0;
            fill <= '0;
        end else if (shift_en) begin
            mem[0] <= wr_data;
            for (int i = 1; i < SEARCH_LEN; i++) mem[i] <= mem[i-1];
            if (fill != OFS_W'(SEARCH_LEN)) fill <= fill + 4'd1;
        end
    end

    // Offsets past the window read as zero.
    always_comb begin
        rd_data = '0;
        if (rd_pos < OFS_W'(SEARCH_LEN)) begin
            rd_data = mem[rd_pos];
        end else begin
            rd_data = '0;
        end
    end
endmodule

// File: rtl/lz77_decoder.sv
// LZ77 decoder: expands (offset, length, char) codes into a byte stream,
// one byte per cycle, accepting the next code on the literal's closing edge.
module lz77_decoder
    import lz77_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             code_valid,
    input  logic             code_last,
    input  logic [OFS_W-1:0] code_pos,
    input  logic [LEN_W-1:0] code_len,
    input  logic [DW-1:0]    code_char,
    output logic             busy,
    output logic             valid,
    output logic [DW-1:0]    char_out,
    output logic             finish,
    output logic             err
);
    state_t           state;
    logic [LEN_W-1:0] rem_r;
    logic [OFS_W-1:0] pos_r;
    logic [DW-1:0]    char_r;
    logic             last_r;

    logic             accept_s;
    logic             emit_s;
    logic [DW-1:0]    byte_s;
    logic [OFS_W-1:0] rd_pos_s;
    logic [DW-1:0]    rd_data_s;
    logic [OFS_W-1:0] fill_s;
    logic             illegal_s;

    lz77_search_buf u_buf (
        .clk      (clk),
        .reset    (reset),
        .shift_en (emit_s),
        .wr_data  (byte_s),
        .rd_pos   (rd_pos_s),
        .rd_data  (rd_data_s),
        .fill     (fill_s)
    );

    // Select the byte produced this edge; the first copy byte reads the live code_pos.
    always_comb begin
        accept_s  = code_valid && !busy;
        rd_pos_s  = (state == COPY) ? pos_r : code_pos;
        emit_s    = 1'b0;
        byte_s    = '0;
        illegal_s = (code_len > LEN_W'(MAX_MATCH)) ||
                    ((code_len != 4'd0) && (code_pos >= fill_s)) ||
                    (code_pos >= OFS_W'(SEARCH_LEN));
        case (state)
            COPY: begin
                emit_s = 1'b1;
                byte_s = (rem_r != 4'd0) ? rd_data_s : char_r;
            end
            default: begin
                if (accept_s) begin
                    emit_s = 1'b1;
                    byte_s = (code_len == 4'd0) ? code_char : rd_data_s;
                end else begin
                    emit_s = 1'b0;
                    byte_s = '0;
                end
            end
        endcase
    end

    // FSM: rem_r counts copy bytes still owed after the one now on the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rem_r    <= '0;
            pos_r    <= '0;
            char_r   <= '0;
            last_r   <= 1'b0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            char_out <= '0;
            finish   <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                COPY: begin
                    valid    <= 1'b1;
                    char_out <= byte_s;
                    if (rem_r != 4'd0) begin
                        rem_r  <= rem_r - 4'd1;
                        busy   <= 1'b1;
                        finish <= 1'b0;
                    end else begin
                        state  <= LIT;
                        busy   <= 1'b0;
                        finish <= last_r;
                    end
                end
                default: begin
                    if (accept_s) begin
                        pos_r    <= code_pos;
                        char_r   <= code_char;
                        last_r   <= code_last;
                        valid    <= 1'b1;
                        char_out <= byte_s;
                        err      <= err | illegal_s;
                        if (code_len == 4'd0) begin
                            state  <= LIT;
                            busy   <= 1'b0;
                            finish <= code_last;
                        end else begin
                            state  <= COPY;
                            rem_r  <= code_len - 4'd1;
                            busy   <= 1'b1;
                            finish <= 1'b0;
                        end
                    end else begin
                        state  <= IDLE;
                        valid  <= 1'b0;
                        busy   <= 1'b0;
                        finish <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
